key_debounce_multi: RTL and testbench
=====================================

# key_debounce_multi

Parametrised multi-channel key debouncer, the successor to the single-key 20 ms filter. It synchronises KEY_NUM raw mechanical key inputs and debounces presses and releases independently per key. It emits a debounced level and one-cycle press/release pulses, plus long-press and auto-repeat pulses. It sits between board key pins and UI/control logic; bit n of key_press is a drop-in for the legacy single-key press flag.

## Interface
- KEY_NUM, 4: number of independent key channels (1..32)
- CNT_MAX, 999_999: debounce stable-count limit (20 ms at 50 MHz)
- LONG_MAX, 49_999_999: hold-count limit for long-press (1 s at 50 MHz)
- REPEAT_MAX, 9_999_999: auto-repeat period limit (200 ms); must be ≤ LONG_MAX
- REPEAT_EN, 1: 1 = generate key_repeat pulses after long-press; 0 = key_repeat tied 0
- ACTIVE_LOW, 1: 1 = pressed key reads 0 on key_in; 0 = pressed reads 1

Ports:
- sys_clk  in  1  clock
- sys_rst_n  in  1  reset, asynchronous, active-low
- key_in  in  KEY_NUM  raw asynchronous key pins
- key_state  out  KEY_NUM  debounced level, 1 = pressed
- key_press  out  KEY_NUM  one-cycle pulse on debounced press
- key_release  out  KEY_NUM  one-cycle pulse on debounced release
- key_long  out  KEY_NUM  one-cycle pulse once per press when held LONG_MAX
- key_repeat  out  KEY_NUM  one-cycle pulse every REPEAT_MAX+1 cycles after key_long while held

## Operation
- Per channel: 2-FF synchroniser, then `act` = synchronised value XOR ACTIVE_LOW inverted, so that act = 1 means pressed.
- Per-channel FSM with states IDLE, PRESS_DEB, HELD and REL_DEB. The debounce counter dcnt is $clog2(CNT_MAX+1) bits. The hold counter hcnt is $clog2(LONG_MAX+1) bits. A 1-bit flag `long_done` tracks whether key_long has fired.
- IDLE, act=1: go to PRESS_DEB, dcnt←0.
- PRESS_DEB:
  - act=0: go to IDLE.
  - dcnt==CNT_MAX: go to HELD, key_press←1, key_state←1, hcnt←0, long_done←0.
  - Otherwise dcnt++.
- HELD:
  - act=0: go to REL_DEB, dcnt←0.
  - !long_done and hcnt==LONG_MAX: key_long←1, long_done←1, hcnt←0.
  - long_done, REPEAT_EN, hcnt==REPEAT_MAX: key_repeat←1, hcnt←0.
  - Otherwise hcnt++. With REPEAT_EN=0 and long_done=1, hcnt holds.
- REL_DEB:
  - act=1: return to HELD. hcnt and long_done are retained, so a release glitch never restarts long/repeat timing. hcnt does not advance in REL_DEB.
  - dcnt==CNT_MAX: go to IDLE, key_release←1, key_state←0.
  - Otherwise dcnt++.
- All pulse outputs are registered and high for exactly one cycle.
- Channels are fully independent. Any mix of pulses may assert on the same cycle across channels.
- Reset, asynchronous at any time:
  - Synchronisers load the released level.
  - FSMs go to IDLE; counters and long_done clear.
  - All outputs go to 0.
  - A key held across reset deassertion is detected as a fresh press after full debounce. No release pulse is emitted for a key pressed at reset.

## Timing
- Raw edge to FSM: 2 cycles (synchroniser) plus 1 cycle (FSM entry).
- Press latency: key_in asserted stably before edge 1 puts key_press high in the cycle after edge CNT_MAX+4. key_state rises on the same edge.
- Release latency is symmetric: key_release pulses after edge CNT_MAX+4 counted from the raw release. key_state falls on the same edge.
- Any act change during PRESS_DEB or REL_DEB aborts the debounce. The next attempt restarts from dcnt=0.
- key_long is asserted LONG_MAX+1 cycles after key_press, provided there is no REL_DEB excursion.
- First key_repeat is REPEAT_MAX+1 cycles after key_long. Subsequent repeats follow at the same period.
- In HELD, if the long/repeat terminal count coincides with act=0, the REL_DEB transition takes priority and no pulse is emitted.

## Structure
- Shared package key_pkg holds:
  - FSM state encoding (2-bit localparams).
  - Default timing constants for a 50 MHz clock: 20 ms, 1 s, 200 ms.
- Sub-module key_chan holds one channel (synchroniser, FSM, counters). key_debounce_multi instantiates it KEY_NUM times via generate.

## Test plan
Bench parameters: KEY_NUM=4, CNT_MAX=9, LONG_MAX=49, REPEAT_MAX=19, ACTIVE_LOW=1.
- Reset: assert sys_rst_n=0 with key_in=4'b0000 → all outputs 0. After release, key_state=4'b0001 appears only after edge 13, with key_press[0] pulsed.
- Bounce: key_in[0] toggles 0/1 every 4 cycles for 40 cycles, then holds 0 → zero key_press during bouncing. A single key_press[0] occurs after the 13th edge of stable 0.
- Short press: hold key_in[1]=0 for 30 cycles, then 1 → one key_press[1]; key_release[1] after edge 13 post-release; key_long[1] and key_repeat[1] stay 0.
- Long/repeat: hold key_in[2]=0 for 150 cycles:
  - key_press at edge 13.
  - key_long at edge 63.
  - key_repeat at edges 83, 103, 123, 143.
  - Exactly one key_long.
- Glitch in HELD: a 3-cycle key_in[2]=1 blip at cycle 40 → no key_release. key_long is delayed by exactly the REL_DEB cycles spent.
- Concurrency and mid-reset: press key_in[0] and key_in[3] on the same cycle → key_press=4'b1001 in one cycle. Assert reset at cycle 30 while held → outputs 0 immediately, with no spurious key_release after reset deasserts.

Source files
------------

// File: rtl/key_pkg.sv
// Shared definitions for the multi-channel key debouncer: FSM encoding,
// default 50 MHz timing constants and a counter-width helper.
package key_pkg;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_PRESS_DEB = 2'd1;
    localparam logic [1:0] ST_HELD      = 2'd2;
    localparam logic [1:0] ST_REL_DEB   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE      = ST_IDLE,
        S_PRESS_DEB = ST_PRESS_DEB,
        S_HELD      = ST_HELD,
        S_REL_DEB   = ST_REL_DEB
    } key_fsm_e;

    localparam int unsigned CLK_HZ         = 50_000_000;
    localparam int unsigned DEB_CNT_DEF    = 999_999;     // 20 ms
    localparam int unsigned LONG_CNT_DEF   = 49_999_999;  // 1 s
    localparam int unsigned REPEAT_CNT_DEF = 9_999_999;   // 200 ms

    // Width of a counter that must reach max_val; never narrower than 1 bit.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/key_chan.sv
// One key channel: 2-FF synchroniser, debounce FSM, hold/repeat timing and
// registered level/pulse outputs.
module key_chan
    import key_pkg::*;
#(
    parameter int unsigned CNT_MAX    = DEB_CNT_DEF,
    parameter int unsigned LONG_MAX   = LONG_CNT_DEF,
    parameter int unsigned REPEAT_MAX = REPEAT_CNT_DEF,
    parameter bit          REPEAT_EN  = 1'b1,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key_i,
    output logic state_o,
    output logic press_o,
    output logic release_o,
    output logic long_o,
    output logic repeat_o
);

    localparam int unsigned DW = cnt_width(CNT_MAX);
    localparam int unsigned HW = cnt_width(LONG_MAX);
    localparam logic [DW-1:0] DCNT_LAST = DW'(CNT_MAX);
    localparam logic [HW-1:0] HCNT_LONG = HW'(LONG_MAX);
    localparam logic [HW-1:0] HCNT_REP  = HW'(REPEAT_MAX);
    localparam logic          REL_LVL   = ACTIVE_LOW;

    logic [1:0]    sync_q;
    logic          act;
    key_fsm_e      state_q, state_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic          long_done_q, long_done_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          long_q, long_d;
    logic          repeat_q, repeat_d;

    // Synchroniser resets to the released level so a key held through reset
    // is seen as a fresh press rather than a release.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync_q <= {2{REL_LVL}};
        end else begin
            sync_q <= {sync_q[0], key_i};
        end
    end

    assign act = sync_q[1] ^ ACTIVE_LOW;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= S_IDLE;
            dcnt_q      <= '0;
            hcnt_q      <= '0;
            long_done_q <= 1'b0;
            level_q     <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
            repeat_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            dcnt_q      <= dcnt_d;
            hcnt_q      <= hcnt_d;
            long_done_q <= long_done_d;
            level_q     <= level_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
            repeat_q    <= repeat_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        dcnt_d      = dcnt_q;
        hcnt_d      = hcnt_q;
        long_done_d = long_done_q;
        level_d     = level_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        long_d      = 1'b0;
        repeat_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (act) begin
                    state_d = S_PRESS_DEB;
                    dcnt_d  = '0;
                end
            end
            S_PRESS_DEB: begin
                if (!act) begin
                    state_d = S_IDLE;
                end else if (dcnt_q == DCNT_LAST) begin
                    state_d     = S_HELD;
                    press_d     = 1'b1;
                    level_d     = 1'b1;
                    hcnt_d      = '0;
                    long_done_d = 1'b0;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            S_HELD: begin
                // Release takes priority over a coinciding long/repeat terminal count.
                if (!act) begin
                    state_d = S_REL_DEB;
                    dcnt_d  = '0;
                end else if (!long_done_q && hcnt_q == HCNT_LONG) begin
                    long_d      = 1'b1;
                    long_done_d = 1'b1;
                    hcnt_d      = '0;
                end else if (long_done_q && REPEAT_EN && hcnt_q == HCNT_REP) begin
                    repeat_d = 1'b1;
                    hcnt_d   = '0;
                end else if (!long_done_q || REPEAT_EN) begin
                    hcnt_d = hcnt_q + 1'b1;
                end
            end
            S_REL_DEB: begin
                // hcnt and long_done are left untouched so a glitch only pauses hold timing.
                if (act) begin
                    state_d = S_HELD;
                end else if (dcnt_q == DCNT_LAST) begin
                    state_d   = S_IDLE;
                    release_d = 1'b1;
                    level_d   = 1'b0;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign state_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign long_o    = long_q;
    assign repeat_o  = repeat_q;

endmodule

// File: rtl/key_debounce_multi.sv
// KEY_NUM independent debounced key channels with press/release/long/repeat
// pulses; bit n of key_press replaces the legacy single-key press flag.
module key_debounce_multi
    import key_pkg::*;
#(
    parameter int unsigned KEY_NUM    = 4,
    parameter int unsigned CNT_MAX    = DEB_CNT_DEF,
    parameter int unsigned LONG_MAX   = LONG_CNT_DEF,
    parameter int unsigned REPEAT_MAX = REPEAT_CNT_DEF,  // keep <= LONG_MAX
    parameter int          REPEAT_EN  = 1,
    parameter int          ACTIVE_LOW = 1
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic [KEY_NUM-1:0] key_in,
    output logic [KEY_NUM-1:0] key_state,
    output logic [KEY_NUM-1:0] key_press,
    output logic [KEY_NUM-1:0] key_release,
    output logic [KEY_NUM-1:0] key_long,
    output logic [KEY_NUM-1:0] key_repeat
);

    generate
        for (genvar gi = 0; gi < KEY_NUM; gi++) begin : g_chan
            key_chan #(
                .CNT_MAX    (CNT_MAX),
                .LONG_MAX   (LONG_MAX),
                .REPEAT_MAX (REPEAT_MAX),
                .REPEAT_EN  (REPEAT_EN != 0),
                .ACTIVE_LOW (ACTIVE_LOW != 0)
            ) u_chan (
                .sys_clk   (sys_clk),
                .sys_rst_n (sys_rst_n),
                .key_i     (key_in[gi]),
                .state_o   (key_state[gi]),
                .press_o   (key_press[gi]),
                .release_o (key_release[gi]),
                .long_o    (key_long[gi]),
                .repeat_o  (key_repeat[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_key_debounce_multi.sv
// Self-checking bench: directed scenarios plus random key traffic, compared
// every cycle against a run-length/hold-time reference model.
module tb_key_debounce_multi;

    localparam int KN = 4;
    localparam int CM = 9;
    localparam int LM = 49;
    localparam int RM = 19;

    logic          sys_clk = 1'b0;
    logic          sys_rst_n;
    logic [KN-1:0] key_in;
    logic [KN-1:0] key_state, key_press, key_release, key_long, key_repeat;

    key_debounce_multi #(
        .KEY_NUM(KN), .CNT_MAX(CM), .LONG_MAX(LM), .REPEAT_MAX(RM),
        .REPEAT_EN(1), .ACTIVE_LOW(1)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .key_in      (key_in),
        .key_state   (key_state),
        .key_press   (key_press),
        .key_release (key_release),
        .key_long    (key_long),
        .key_repeat  (key_repeat)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: a key toggles its debounced level once its pressed
    // reading has disagreed with that level for CM+2 consecutive samples;
    // hold time advances on samples that are pressed and steady.
    bit m_s1[KN], m_s2[KN], m_db[KN];
    int m_run[KN], m_ticks[KN];
    logic [KN-1:0] e_state, e_press, e_rel, e_long, e_rep;

    task automatic model_reset();
        for (int c = 0; c < KN; c++) begin
            m_s1[c] = 0; m_s2[c] = 0; m_db[c] = 0; m_run[c] = 0; m_ticks[c] = 0;
        end
    endtask

    task automatic model_step();
        bit act;
        e_press = '0; e_rel = '0; e_long = '0; e_rep = '0;
        for (int c = 0; c < KN; c++) begin
            act     = m_s2[c];
            m_s2[c] = m_s1[c];
            m_s1[c] = ~key_in[c];
            if (act != m_db[c]) begin
                m_run[c]++;
            end else begin
                if (m_db[c] && m_run[c] == 0) begin
                    m_ticks[c]++;
                    if (m_ticks[c] == LM + 1)
                        e_long[c] = 1'b1;
                    else if (m_ticks[c] > LM + 1 && (m_ticks[c] - LM - 1) % (RM + 1) == 0)
                        e_rep[c] = 1'b1;
                end
                m_run[c] = 0;
            end
            if (m_run[c] == CM + 2) begin
                m_db[c]  = act;
                m_run[c] = 0;
                if (act) begin
                    e_press[c] = 1'b1;
                    m_ticks[c] = 0;
                end else begin
                    e_rel[c] = 1'b1;
                end
            end
        end
        for (int c = 0; c < KN; c++) e_state[c] = m_db[c];
    endtask

    // Observed pulse statistics since the last clear_stats.
    int edge_n;
    int n_press[KN], n_rel[KN], n_long[KN], n_rep[KN];
    int press_at[KN], rel_at[KN], long_at[KN];
    int rep_at2[$];

    task automatic clear_stats();
        edge_n = 0;
        rep_at2.delete();
        for (int c = 0; c < KN; c++) begin
            n_press[c] = 0; n_rel[c] = 0; n_long[c] = 0; n_rep[c] = 0;
            press_at[c] = -1; rel_at[c] = -1; long_at[c] = -1;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge sys_clk);
        #1;
        edge_n++;
        check("state",   key_state,   e_state);
        check("press",   key_press,   e_press);
        check("release", key_release, e_rel);
        check("long",    key_long,    e_long);
        check("repeat",  key_repeat,  e_rep);
        for (int c = 0; c < KN; c++) begin
            if (key_press[c])   begin n_press[c]++; if (press_at[c] < 0) press_at[c] = edge_n; end
            if (key_release[c]) begin n_rel[c]++;   if (rel_at[c] < 0)   rel_at[c]   = edge_n; end
            if (key_long[c])    begin n_long[c]++;  if (long_at[c] < 0)  long_at[c]  = edge_n; end
            if (key_repeat[c])  n_rep[c]++;
        end
        if (key_repeat[2]) rep_at2.push_back(edge_n);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Asynchronous reset applied between edges; outputs must clear at once.
    task automatic do_reset(input logic [KN-1:0] keys_after);
        sys_rst_n = 1'b0;
        #1;
        check("rst_async", {key_state, key_press, key_release, key_long, key_repeat}, 32'h0);
        model_reset();
        repeat (2) @(posedge sys_clk);
        key_in = keys_after;
        #2;
        sys_rst_n = 1'b1;
    endtask

    int dur[KN];

    initial begin
        sys_rst_n = 1'b0;
        key_in    = 4'b0000;
        model_reset();
        clear_stats();

        // Reset with all keys pressed, then only key 0 kept pressed.
        repeat (3) @(posedge sys_clk);
        #1;
        check("rst_out", {key_state, key_press, key_release, key_long, key_repeat}, 32'h0);
        key_in = 4'b1110;
        #1;
        sys_rst_n = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 12) check("rst_state_e12", key_state, 4'b0000);
            if (i == 13) check("rst_state_e13", key_state, 4'b0001);
        end
        check("rst_press_edge", press_at[0], 13);
        check("rst_press_cnt", n_press[0], 1);
        check("rst_no_release", n_rel[0], 0);
        key_in = 4'hF;
        ticks(20);

        // Bounce on key 0.
        clear_stats();
        for (int i = 0; i < 40; i++) begin
            key_in[0] = ((i / 4) % 2 == 1);
            tick();
        end
        check("bounce_no_press", n_press[0], 0);
        clear_stats();
        key_in[0] = 1'b0;
        ticks(20);
        check("bounce_press_edge", press_at[0], 13);
        check("bounce_press_cnt", n_press[0], 1);
        key_in = 4'hF;
        ticks(20);

        // Short press on key 1.
        clear_stats();
        key_in[1] = 1'b0;
        ticks(30);
        key_in[1] = 1'b1;
        ticks(20);
        check("short_press_cnt", n_press[1], 1);
        check("short_rel_cnt", n_rel[1], 1);
        check("short_rel_edge", rel_at[1] - 30, 13);
        check("short_no_long", n_long[1] + n_rep[1], 0);

        // Long press and auto-repeat on key 2.
        clear_stats();
        key_in[2] = 1'b0;
        ticks(150);
        check("long_press_edge", press_at[2], 13);
        check("long_edge", long_at[2], 63);
        check("long_cnt", n_long[2], 1);
        check("repeat_cnt", n_rep[2], 4);
        if (rep_at2.size() == 4) begin
            check("repeat_e0", rep_at2[0], 83);
            check("repeat_e1", rep_at2[1], 103);
            check("repeat_e2", rep_at2[2], 123);
            check("repeat_e3", rep_at2[3], 143);
        end else begin
            check("repeat_list_len", rep_at2.size(), 4);
        end
        key_in = 4'hF;
        ticks(20);

        // Release glitch while held on key 2.
        clear_stats();
        for (int i = 1; i <= 120; i++) begin
            key_in[2] = (i >= 41 && i <= 43);
            tick();
        end
        check("glitch_no_release", n_rel[2], 0);
        check("glitch_long_cnt", n_long[2], 1);
        check("glitch_long_late", long_at[2] > 63, 1);
        key_in = 4'hF;
        ticks(20);

        // Concurrent press on keys 0 and 3, then reset while held.
        clear_stats();
        key_in = 4'b0110;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (i == 13) check("conc_press", key_press, 4'b1001);
        end
        do_reset(4'hF);
        clear_stats();
        ticks(30);
        check("midrst_no_release", n_rel[0] + n_rel[3], 0);
        check("midrst_no_press", n_press[0] + n_press[3], 0);

        // Random traffic with one asynchronous reset part-way through.
        for (int c = 0; c < KN; c++) dur[c] = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int c = 0; c < KN; c++) begin
                if (dur[c] == 0) begin
                    key_in[c] = 1'($urandom_range(0, 1));
                    dur[c] = key_in[c] ? $urandom_range(1, 40) : $urandom_range(1, 160);
                end
                dur[c]--;
            end
            tick();
            if (cyc == 1500) do_reset(key_in);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
